// File: rtl/bit_packer_pkg.sv
// Shared types and constants for the serial-to-parallel bit packer.
package bit_packer_pkg;

    localparam int unsigned BIT_PACKER_WIDTH_DEFAULT = 3;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/bit_packer.sv
// Collects serial bits (bit 0 first) into WIDTH-bit words with a valid/ready output and a flush for partial words.
// Optional feature: define BIT_PACKER_PARITY_EN to add the out_parity output.
module bit_packer
    import bit_packer_pkg::*;
#(
    parameter int unsigned WIDTH = BIT_PACKER_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_bit,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_vec,
`ifdef BIT_PACKER_PARITY_EN
    output logic [$clog2(WIDTH+1)-1:0] out_len,
    output logic                       out_parity
`else
    output logic [$clog2(WIDTH+1)-1:0] out_len
`endif
);

    localparam int unsigned LEN_W = $clog2(WIDTH + 1);

    state_e             state_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sh_q;

    logic               accept_c;
    logic               last_c;
    logic               emit_c;
    logic [WIDTH-1:0]   ins_vec_c;
    logic [WIDTH-1:0]   load_vec_c;
    logic [LEN_W-1:0]   load_len_c;

    // Ready is held low during reset so nothing is taken until the block is out of it.
    assign in_ready = ~reset & ((state_q == FILL) | out_ready);

    always_comb begin
        accept_c   = in_valid & in_ready;
        ins_vec_c  = sh_q | (WIDTH'(in_bit) << cnt_q);
        last_c     = accept_c && (cnt_q == LEN_W'(WIDTH - 1));
        emit_c     = last_c || (flush && ((cnt_q != '0) || accept_c));
        load_vec_c = accept_c ? ins_vec_c : sh_q;
        load_len_c = LEN_W'(cnt_q + LEN_W'(accept_c));
    end

    // A same-cycle accepted bit counts toward a flushed word's length.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            sh_q       <= '0;
            out_valid  <= 1'b0;
            out_vec    <= '0;
            out_len    <= '0;
`ifdef BIT_PACKER_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (state_q == FILL) begin
            if (emit_c) begin
                state_q    <= HOLD;
                out_valid  <= 1'b1;
                out_vec    <= load_vec_c;
                out_len    <= load_len_c;
`ifdef BIT_PACKER_PARITY_EN
                out_parity <= ^load_vec_c;
`endif
                sh_q       <= '0;
                cnt_q      <= '0;
            end else if (accept_c) begin
                sh_q  <= ins_vec_c;
                cnt_q <= LEN_W'(cnt_q + LEN_W'(1));
            end
        end else begin
            if (out_ready) begin
                state_q   <= FILL;
                out_valid <= 1'b0;
                if (accept_c) begin
                    sh_q  <= WIDTH'(in_bit);
                    cnt_q <= LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer at WIDTH=3; parity checks are compiled in with BIT_PACKER_PARITY_EN.
module tb_bit_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_vec;
    logic [1:0] out_len;
`ifdef BIT_PACKER_PARITY_EN
    logic       out_parity;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_packer #(.WIDTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
`ifdef BIT_PACKER_PARITY_EN
        .out_len   (out_len),
        .out_parity(out_parity)
`else
        .out_len   (out_len)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic f, input logic r);
        in_valid  = v;
        in_bit    = b;
        flush     = f;
        out_ready = r;
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [2:0] v, input logic [1:0] l);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_vec"},   32'(out_vec),   32'(v));
        chk({tag, "_len"},   32'(out_len),   32'(l));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_vec",   32'(out_vec),   32'd0);
        chk("rst_out_len",   32'(out_len),   32'd0);
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);

        // Full word 0,1,1 with consumer ready.
        drive(1'b1, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("full_no_valid_yet", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_word("full", 3'b110, 2'd3);
`ifdef BIT_PACKER_PARITY_EN
        chk("parity_110", 32'(out_parity), 32'd0);
`endif
        tick();
        chk("full_one_cycle", 32'(out_valid), 32'd0);

        // Backpressure on word 1,0,1; blocked input and flush must be ignored.
        drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            chk_word("bp_hold", 3'b101, 2'd3);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_word("bp_release", 3'b101, 2'd3);
        chk("bp_in_ready_rel", 32'(in_ready), 32'd1);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Drain and accept in the same cycle.
        drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk_word("sim_first", 3'b010, 2'd2 + 2'd1);
        tick();
        chk("sim_drained", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1); tick();
        chk("sim_mid", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_word("sim_second", 3'b001, 2'd3);
        tick();

        // Flush of a two-bit partial word, then flush on an empty buffer.
        drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_word("flush2", 3'b011, 2'd2);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_empty", 32'(out_valid), 32'd0);

        // Flush with a same-cycle bit, alone and completing a word.
        drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_word("flush_same1", 3'b001, 2'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_word("flush_full", 3'b110, 2'd3);
        tick();

        // Reset mid-word discards buffered bits.
        drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1); tick();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1); tick();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rmid_no_valid", 32'(out_valid), 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
        chk("rmid_still_empty", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk_word("rmid_word", 3'b111, 2'd3);
`ifdef BIT_PACKER_PARITY_EN
        chk("parity_111", 32'(out_parity), 32'd1);
`endif

        // Reset while holding drops the word.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rhold_valid", 32'(out_valid), 32'd0);
        chk("rhold_vec",   32'(out_vec),   32'd0);
        chk("rhold_len",   32'(out_len),   32'd0);
        chk("rhold_ready", 32'(in_ready),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH SHALL default to 3 and set the assembled word width, with a legal range of 2..32.
REQ-003 Port clk SHALL be an input, 1 bit wide: rising-edge clock.
REQ-004 Port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: in_bit is valid.
REQ-006 Port in_bit SHALL be an input, 1 bit wide: the serial data bit.
REQ-007 Port in_ready SHALL be an output, 1 bit wide: the block accepts in_bit this cycle.
REQ-008 Port flush SHALL be an input, 1 bit wide: a pulse that emits a partial word.
REQ-009 Port out_valid SHALL be an output, 1 bit wide: out_vec and out_len are valid.
REQ-010 Port out_ready SHALL be an input, 1 bit wide: the consumer takes the word this cycle.
REQ-011 Port out_vec SHALL be an output, WIDTH bits wide: the assembled word, with bit 0 collected first.
REQ-012 Port out_len SHALL be an output, $clog2(WIDTH+1) bits wide: the number of valid bits in out_vec.

Function
REQ-013 The block SHALL implement two states, FILL and HOLD, and SHALL enter FILL on reset.
REQ-014 A bit SHALL be accepted when in_valid and in_ready are both high.
REQ-015 In FILL, each accepted bit SHALL be written to shift position cnt, and cnt SHALL increment by 1.
REQ-016 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 When cnt==WIDTH-1 and a bit is accepted, the block SHALL move to HOLD with out_len=WIDTH and cnt=0.
REQ-018 This gives a latency of 1 cycle from the last accepted bit to out_valid.
REQ-019 In HOLD, out_valid SHALL be 1, and out_vec and out_len SHALL stay stable until out_ready is high.
REQ-020 In HOLD, in_ready SHALL equal out_ready.
REQ-021 If a bit is accepted in the same cycle as the word is drained, that bit SHALL become bit 0 of the next word, with cnt=1 and state FILL.
REQ-022 When HOLD drains with no accepted bit, the block SHALL go to FILL with cnt=0.
REQ-023 A flush in FILL with cnt>0 SHALL move the block to HOLD with the unfilled upper bits as 0 and out_len equal to the bit count.
REQ-024 The flush bit count SHALL include a bit accepted in the same cycle.
REQ-025 If that same-cycle bit completes the word, out_len SHALL be WIDTH.
REQ-026 A flush in FILL with cnt==0 and no accepted bit SHALL be ignored.
REQ-027 A flush in HOLD SHALL be ignored.
REQ-028 The bit counter SHALL wrap from WIDTH-1 to 0 only on word completion and SHALL never exceed WIDTH-1.
REQ-029 In FILL, unfilled upper bits of the shift register SHALL read as 0.

Reset
REQ-030 On reset: state=FILL, cnt=0, shift register=0, out_valid=0, out_vec=0, out_len=0.
REQ-031 On reset, in_ready SHALL go to 1 in the cycle after reset deasserts.
REQ-032 A reset asserted mid-word or in HOLD SHALL discard all buffered bits without emitting a word.
REQ-033 While reset is high, in_valid and flush SHALL be ignored.

Configuration
REQ-034 With macro BIT_PACKER_PARITY_EN defined, the block SHALL add output port out_parity, 1 bit wide.
REQ-035 out_parity SHALL be the XOR of out_vec, registered with out_vec, and valid with out_valid.
REQ-036 out_parity SHALL reset to 0.
REQ-037 Without BIT_PACKER_PARITY_EN, the out_parity port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-038 Package bit_packer_pkg SHALL hold the state enum (FILL, HOLD) and the default-width constant BIT_PACKER_WIDTH_DEFAULT=3.
REQ-039 The block SHALL have no sub-module; the counter, shift register and FSM SHALL be inline.

Verification
REQ-040 Full word (WIDTH=3): bits 0,1,1 on consecutive cycles, out_ready=1 -> out_vec=3'b110, out_len=3, with out_valid for 1 cycle starting the cycle after the third bit.
REQ-041 Backpressure: complete a word with out_ready=0 for 4 cycles -> out_valid held, out_vec stable, in_ready=0; release out_ready -> drain in 1 cycle.
REQ-042 Simultaneous drain and accept: in HOLD, out_ready=1 with in_valid=1 and in_bit=1 -> word drains and next word starts with cnt=1 and bit0=1; the following bits 0,0 -> out_vec=3'b001.
REQ-043 Flush: bits 1,1 then flush -> out_vec=3'b011, out_len=2; flush with cnt=0 -> no out_valid.
REQ-044 Reset mid-word: bits 1,0, then reset, then bits 1,1,1 -> the only word emitted is 3'b111, out_len=3.
REQ-045 With BIT_PACKER_PARITY_EN: word 3'b110 -> out_parity=0; word 3'b111 -> out_parity=1.
